// File: rtl/mac_operand_feeder.sv
// Sequences one dot product into a signed 8x8 MAC lane: clear, feed N pairs, capture the sum.
// Latency: last pair fire in cycle T -> res_valid_o from T+3 (len=0: cmd fire T -> T+3).
// Backpressure: A/B consumed only together; new commands wait until the result slot is free.
// Optional: define MAC_FEED_STALL_CNT_EN to add stall_cnt_o (bubble cycles during FEED).
module mac_operand_feeder #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             a_valid_i,
    input  logic [7:0]       a_data_i,
    output logic             a_ready_o,
    input  logic             b_valid_i,
    input  logic [7:0]       b_data_i,
    output logic             b_ready_o,
    output logic [7:0]       mac_a_o,
    output logic [7:0]       mac_b_o,
    output logic             mac_clr_o,
    input  logic [31:0]      mac_acc_i,
    output logic             res_valid_o,
    output logic [31:0]      res_data_o,
    input  logic             res_ready_i
`ifdef MAC_FEED_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt_o
`endif
);

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, CAPT} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] len, cnt;
    logic             pair_fire, cmd_fire, res_fire;

    assign pair_fire = (state == FEED) & a_valid_i & b_valid_i;
    assign cmd_fire  = cmd_valid_i & cmd_ready_o;
    assign res_fire  = res_valid_o & res_ready_i;
    assign mac_clr_o = rst | (state == CLR);

    always_comb begin
        state_nx    = state;
        cmd_ready_o = 1'b0;
        a_ready_o   = 1'b0;
        b_ready_o   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = !rst & (!res_valid_o | res_ready_i);
                if (cmd_fire) state_nx = CLR;
            end
            CLR:  state_nx = (len == '0) ? CAPT : FEED;
            FEED: begin
                // Streams advance in lockstep so A and B never drift apart.
                a_ready_o = !rst & a_valid_i & b_valid_i;
                b_ready_o = !rst & a_valid_i & b_valid_i;
                if (pair_fire && cnt == len - LEN_W'(1)) state_nx = DRAIN;
            end
            DRAIN:   state_nx = CAPT;
            CAPT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            cnt         <= '0;
            mac_a_o     <= '0;
            mac_b_o     <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
        end else begin
            state <= state_nx;
            if (cmd_fire) begin
                len <= cmd_len_i;
                cnt <= '0;
            end else if (pair_fire) begin
                cnt <= cnt + LEN_W'(1);
            end
            // Zero operands outside a fire keep the MAC accumulating nothing in bubbles.
            mac_a_o <= pair_fire ? a_data_i : 8'd0;
            mac_b_o <= pair_fire ? b_data_i : 8'd0;
            if (state == CAPT) begin
                res_data_o  <= mac_acc_i;
                res_valid_o <= 1'b1;
            end else if (res_fire) begin
                res_valid_o <= 1'b0;
            end
        end
    end

`ifdef MAC_FEED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || state == CLR)
            stall_cnt_o <= '0;
        else if (state == FEED && !pair_fire && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural signed MAC attached.
module tb_mac_operand_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [15:0] cmd_len_i;
    logic        a_valid_i, a_ready_o;
    logic [7:0]  a_data_i;
    logic        b_valid_i, b_ready_o;
    logic [7:0]  b_data_i;
    logic [7:0]  mac_a_o, mac_b_o;
    logic        mac_clr_o;
    logic [31:0] mac_acc_i;
    logic        res_valid_o;
    logic [31:0] res_data_o;
    logic        res_ready_i;
`ifdef MAC_FEED_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    int lat;
    int clr_cnt;
    bit rdy_viol;
    logic [7:0] va [4];
    logic [7:0] vb [4];

    always #5 clk = ~clk;

    mac_operand_feeder #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
        .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_clr_o(mac_clr_o), .mac_acc_i(mac_acc_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ready_i(res_ready_i)
`ifdef MAC_FEED_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    // Behavioural MAC lane: synchronous clear, signed 8x8 products, 32-bit wrap.
    logic signed [15:0] prod;
    logic        [31:0] acc;
    assign prod      = $signed(mac_a_o) * $signed(mac_b_o);
    assign mac_acc_i = acc;
    always_ff @(posedge clk) begin
        if (mac_clr_o) acc <= '0;
        else           acc <= acc + {{16{prod[15]}}, prod};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n);
        cmd_len_i   = 16'(n);
        cmd_valid_i = 1'b1;
        #1;
        chk("cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        tick();
        cmd_valid_i = 1'b0;
        lat         = 1;
        clr_cnt     = 0;
        rdy_viol    = 1'b0;
    endtask

    // Presents va/vb; with alt set, A is valid only on odd cycles.
    task automatic feed(input int n, input bit alt);
        int  i = 0;
        int  g = 0;
        bit  fired;
        while (i < n && g < 100) begin
            a_valid_i = alt ? (g % 2 == 1) : 1'b1;
            b_valid_i = 1'b1;
            a_data_i  = va[i];
            b_data_i  = vb[i];
            #1;
            if (b_ready_o && !a_valid_i) rdy_viol = 1'b1;
            if (mac_clr_o) clr_cnt++;
            fired = a_ready_o && b_ready_o;
            tick();
            g++;
            if (fired) i++;
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        lat = 1;
        chk("feed_count", 32'(i), 32'(n));
    endtask

    task automatic wait_res(input string tag, input logic [31:0] exp);
        int g = 0;
        while (!res_valid_o && g < 20) begin
            if (a_ready_o || b_ready_o) rdy_viol = 1'b1;
            if (mac_clr_o) clr_cnt++;
            tick();
            lat++;
            g++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_data"}, res_data_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid_i = 1'b0; cmd_len_i = '0;
        a_valid_i = 1'b0; a_data_i = '0; b_valid_i = 1'b0; b_data_i = '0;
        res_ready_i = 1'b1;
        tick(); tick();
        chk("rst_clr", {31'd0, mac_clr_o}, 32'd1);
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        chk("rst_res_data", res_data_o, 32'd0);
        chk("rst_mac_a", {24'd0, mac_a_o}, 32'd0);
        rst = 1'b0;
        tick();

        // len=4 basic dot product, result held one cycle with consumer ready
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        issue(4); feed(4, 1'b0); wait_res("len4", 32'd70);
`ifdef MAC_FEED_STALL_CNT_EN
        chk("len4_stall", {16'd0, stall_cnt_o}, 32'd0);
`endif
        tick();
        chk("len4_one_cycle", {31'd0, res_valid_o}, 32'd0);

        // signed extremes: (-128*-128) + (-1*127)
        va = '{8'h80, 8'hFF, 8'd0, 8'd0};
        vb = '{8'h80, 8'h7F, 8'd0, 8'd0};
        issue(2); feed(2, 1'b0); wait_res("signed", 32'h00003F81);
        tick();

        // len=0: no stream handshake, single clear pulse
        issue(0); wait_res("len0", 32'd0);
        chk("len0_clr_pulses", 32'(clr_cnt), 32'd1);
        chk("len0_no_ready", {31'd0, rdy_viol}, 32'd0);
        tick();

        // bubbles on A only
        va = '{8'd2, 8'd2, 8'd2, 8'd0};
        vb = '{8'd3, 8'd3, 8'd3, 8'd0};
        issue(3); feed(3, 1'b1); wait_res("bubble", 32'd18);
        chk("bubble_b_ready_gated", {31'd0, rdy_viol}, 32'd0);
`ifdef MAC_FEED_STALL_CNT_EN
        chk("bubble_stall", {16'd0, stall_cnt_o}, 32'd2);
`endif
        tick();

        // result backpressure, then accept + new command in the same cycle
        res_ready_i = 1'b0;
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        issue(4); feed(4, 1'b0); wait_res("bp", 32'd70);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", {31'd0, res_valid_o}, 32'd1);
            chk("bp_hold_data", res_data_o, 32'd70);
            chk("bp_cmd_blocked", {31'd0, cmd_ready_o}, 32'd0);
        end
        res_ready_i = 1'b1;
        va = '{8'd5, 8'd0, 8'd0, 8'd0};
        vb = '{8'd6, 8'd0, 8'd0, 8'd0};
        issue(1);
        chk("bp_released", {31'd0, res_valid_o}, 32'd0);
        feed(1, 1'b0); wait_res("bp_next", 32'd30);
        tick();

        // reset in FEED after two 100*100 fires
        cmd_len_i = 16'd4; cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        a_valid_i = 1'b1; b_valid_i = 1'b1; a_data_i = 8'd100; b_data_i = 8'd100;
        tick(); tick(); tick();
        chk("pre_rst_mac_a", {24'd0, mac_a_o}, 32'd100);
        rst = 1'b1;
        tick();
        chk("mid_rst_clr", {31'd0, mac_clr_o}, 32'd1);
        chk("mid_rst_mac_a", {24'd0, mac_a_o}, 32'd0);
        chk("mid_rst_mac_b", {24'd0, mac_b_o}, 32'd0);
        chk("mid_rst_a_ready", {31'd0, a_ready_o}, 32'd0);
        chk("mid_rst_b_ready", {31'd0, b_ready_o}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("mid_rst_res_valid", {31'd0, res_valid_o}, 32'd0);
`ifdef MAC_FEED_STALL_CNT_EN
        chk("mid_rst_stall", {16'd0, stall_cnt_o}, 32'd0);
`endif
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        rst = 1'b0;
        tick();
        va = '{8'd3, 8'd0, 8'd0, 8'd0};
        vb = '{8'd4, 8'd0, 8'd0, 8'd0};
        issue(1); feed(1, 1'b0); wait_res("post_rst", 32'd12);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
Upstream sequencer for the signed 8x8 MAC core (int8 operands, 32-bit accumulator, synchronous clear).
- Accepts a dot-product command of length N.
- Pairs N elements from two int8 valid/ready streams (A row, B column) and drives them into the MAC one pair per cycle.
- Clears the MAC accumulator before the first pair and captures the final 32-bit sum into a held result register with a valid/ready output.
- Sits between the matrix tile loader and one MAC lane.

Parameters:
LEN_W, 16, width of the command length. Max N = 2^LEN_W-1. LEN_W <= 17 guarantees no accumulator overflow, since |product| <= 16384.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_len_i  in  LEN_W  dot-product length N (0 allowed)
a_valid_i  in  1  A element valid
a_data_i  in  8  A element, two's complement
a_ready_o  out  1  A element consumed when valid&ready
b_valid_i  in  1  B element valid
b_data_i  in  8  B element, two's complement
b_ready_o  out  1  B element consumed when valid&ready
mac_a_o  out  8  registered operand to MAC a_i
mac_b_o  out  8  registered operand to MAC b_i
mac_clr_o  out  1  to MAC rst
mac_acc_i  in  32  MAC output_r
res_valid_o  out  1  result valid, held until accepted
res_data_o  out  32  dot-product result
res_ready_i  in  1  result consumer ready

Behaviour:
- Reset (rst=1, any state): state=IDLE; cnt=0; mac_a_o=mac_b_o=0; res_valid_o=0; res_data_o=0; a_ready_o=b_ready_o=0; cmd_ready_o=0.
- mac_clr_o = rst | (state==CLR). Decoded from registers, never from handshake inputs.
- Operand registers: when a pair fires, load a_data_i/b_data_i; in every other cycle load 0. The MAC therefore accumulates 0 when idle or during bubbles.
- IDLE:
  - cmd_ready_o = !res_valid_o | res_ready_i.
  - On command fire: latch len=cmd_len_i, cnt=0, go to CLR.
- CLR (1 cycle): mac_clr_o=1, so the accumulator is 0 after this edge.
  - len==0 -> CAPT.
  - Otherwise -> FEED.
- FEED:
  - a_ready_o = a_valid_i & b_valid_i; b_ready_o = a_valid_i & b_valid_i. Both streams advance together; neither is ever consumed alone.
  - Pair fire = a_valid_i & b_valid_i: cnt++.
  - Fire with cnt==len-1 -> DRAIN.
  - No fire = bubble; stay in FEED.
- DRAIN (1 cycle): last pair is on mac_a_o/mac_b_o and is accumulated at this edge. -> CAPT.
- CAPT (1 cycle): res_data_o<=mac_acc_i, res_valid_o<=1. -> IDLE.
- Latency: last fire in cycle T -> res_valid_o=1 from cycle T+3. For len=0, cmd fire in cycle T -> res_valid_o=1 from cycle T+3.
- Result handshake:
  - res_valid_o clears on res_valid_o&res_ready_i.
  - A CAPT capture cannot collide with a held result, because a command is only accepted once the result slot is free.
  - Accept and new command in the same cycle is allowed.
- a_ready_o and b_ready_o are 0 outside FEED. cmd_ready_o is 0 outside IDLE.
- Arithmetic: the feeder performs none. The accumulator wraps mod 2^32 in the MAC; there is no overflow detection.
- Reset mid-operation: partial sums are discarded, because mac_clr_o is held high during rst. Elements already consumed are lost; the upstream loader reissues.

Optional Feature:
MAC_FEED_STALL_CNT_EN
- Defined: adds output port stall_cnt_o (16 bits), the number of FEED cycles without a pair fire in the current or last command.
  - Cleared in CLR and on rst.
  - Saturates at 0xFFFF.
  - Held stable from DRAIN until the next CLR.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- len=4, A={1,2,3,4}, B={5,6,7,8}, both streams continuously valid, res_ready_i=1 -> res_data_o=70 (0x46); res_valid_o exactly 3 cycles after the 4th fire, for 1 cycle.
- len=2, A={0x80,0xFF}, B={0x80,0x7F} -> res_data_o=16257 (0x00003F81), confirming signed products.
- len=0 -> a_ready_o/b_ready_o never high, mac_clr_o pulses once, res_data_o=0 three cycles after the cmd fire.
- len=3, A={2,2,2} with a_valid_i low on alternate cycles, B={3,3,3} always valid:
  - Result: res_data_o=18.
  - b_ready_o is high only when a_valid_i is high.
  - With macro defined: stall_cnt_o=2.
- Backpressure: result 70 with res_ready_i=0 for 5 cycles -> res_data_o holds 70, cmd_ready_o=0. Then res_ready_i=1 with cmd_valid_i=1 in the same cycle -> both fire, and the next result is independent of 70.
- rst asserted in FEED after 2 fires (values 100*100) -> next cycle all outputs at reset values with mac_clr_o=1. A following len=1, 3*4 command returns 12.
